// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   - Arbitration: round-robin (FIXED_PRIORITY=0) or requester 0 wins (=1).
//   - The granted request drives alu_* in the same cycle. The ALU result is
//     captured on that edge into a one-deep response slot per requester.
//   - A slot can drain and refill on the same edge, so throughput is one op
//     per cycle. A slot that is full and not being drained blocks only its
//     own requester.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   reqN_valid/ready, reqN_<fields>    operation request, N in {0,1}
//   respN_valid/ready/result/error     held ALU result per requester
//   alu_* (out), alu_result/error (in) shared combinational ALU
//   error_count                        saturating count of erroring grants

module alu_arbiter_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic [31:0] din_result,
  input  logic        din_error,
  output logic        valid,
  output logic [31:0] result,
  output logic        error
);
  // A load on the same edge as a drain wins: the slot stays valid and
  // takes the new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      result <= '0;
      error  <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      result <= din_result;
      error  <= din_error;
    end else if (drain) begin
      valid  <= 1'b0;
    end
  end
endmodule

module alu_arbiter #(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [6:0]  req0_opcode,
  input  logic [2:0]  req0_funct3,
  input  logic [6:0]  req0_funct7,
  input  logic [31:0] req0_rs1,
  input  logic [31:0] req0_rs2,
  input  logic [31:0] req0_imm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [6:0]  req1_opcode,
  input  logic [2:0]  req1_funct3,
  input  logic [6:0]  req1_funct7,
  input  logic [31:0] req1_rs1,
  input  logic [31:0] req1_rs2,
  input  logic [31:0] req1_imm,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic [31:0] resp0_result,
  output logic        resp0_error,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp1_result,
  output logic        resp1_error,
  output logic [6:0]  alu_opcode,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_rs1_value,
  output logic [31:0] alu_rs2_value,
  output logic [31:0] alu_imm,
  input  logic [31:0] alu_result,
  input  logic        alu_error,
  output logic [7:0]  error_count
);
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
  } alu_req_t;

  alu_req_t [1:0]        req;
  alu_req_t              alu_sel;
  logic [1:0]            req_valid, resp_ready, slot_valid, slot_error;
  logic [1:0][31:0]      slot_result;
  logic [1:0]            elig, grant;
  logic                  rr_ptr;

  assign req[0]     = '{req0_opcode, req0_funct3, req0_funct7, req0_rs1, req0_rs2, req0_imm};
  assign req[1]     = '{req1_opcode, req1_funct3, req1_funct7, req1_rs1, req1_rs2, req1_imm};
  assign req_valid  = {req1_valid, req0_valid};
  assign resp_ready = {resp1_ready, resp0_ready};

  // A full slot is still eligible when it drains this cycle. The rst_n term
  // keeps ready and the ALU bus quiet while reset is held.
  assign elig = req_valid & (~slot_valid | resp_ready) & {2{rst_n}};

  always_comb begin
    grant = elig;
    if (&elig) begin
      if (FIXED_PRIORITY != 0 || !rr_ptr) grant = 2'b01;
      else                                grant = 2'b10;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_sel = '0;
    if (grant[0])      alu_sel = req[0];
    else if (grant[1]) alu_sel = req[1];
  end

  assign alu_opcode    = alu_sel.opcode;
  assign alu_funct3    = alu_sel.funct3;
  assign alu_funct7    = alu_sel.funct7;
  assign alu_rs1_value = alu_sel.rs1;
  assign alu_rs2_value = alu_sel.rs2;
  assign alu_imm       = alu_sel.imm;

  // The pointer moves to the loser on every grant: granting 0 points at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 1'b0;
      error_count <= '0;
    end else if (|grant) begin
      rr_ptr <= grant[0];
      if (alu_error && error_count != 8'hFF) error_count <= error_count + 8'd1;
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_slot
    alu_arbiter_slot u_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (grant[n]),
      .drain      (slot_valid[n] & resp_ready[n]),
      .din_result (alu_result),
      .din_error  (alu_error),
      .valid      (slot_valid[n]),
      .result     (slot_result[n]),
      .error      (slot_error[n])
    );
  end

  assign resp0_valid  = slot_valid[0];
  assign resp1_valid  = slot_valid[1];
  assign resp0_result = slot_result[0];
  assign resp1_result = slot_result[1];
  assign resp0_error  = slot_error[0];
  assign resp1_error  = slot_error[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Two instances share the same stimulus: index 0 is
// round-robin, index 1 is fixed priority. Each instance has its own emulated
// ALU and its own behavioural model entry.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // request side, indexed by requester
  logic [1:0]       v, rsp_rdy;
  logic [1:0][6:0]  r_op, r_f7;
  logic [1:0][2:0]  r_f3;
  logic [1:0][31:0] r_rs1, r_rs2, r_imm;

  // DUT outputs, indexed [instance][requester]
  logic [1:0][1:0]       q_rdy, p_v, p_err;
  logic [1:0][1:0][31:0] p_res;
  logic [1:0][7:0]       ecnt;
  logic [1:0][6:0]       a_op, a_f7;
  logic [1:0][2:0]       a_f3;
  logic [1:0][31:0]      a_rs1, a_rs2, a_imm, a_res;
  logic [1:0]            a_err;

  int n_cmp = 0;
  int n_err = 0;

  // Reference ALU: {error, result}.
  function automatic logic [32:0] alu_fn(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                         logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    case (op)
      7'h00: return 33'd0;
      7'h13: return {1'b0, a + imm};
      7'h33: begin
        if (f7 == 7'h20 && f3 == 3'd0) return {1'b0, a - b};
        if (f7 != 7'h00) return {1'b1, 32'd0};
        case (f3)
          3'd0:    return {1'b0, a + b};
          3'd4:    return {1'b0, a ^ b};
          3'd6:    return {1'b0, a | b};
          3'd7:    return {1'b0, a & b};
          default: return {1'b0, a << b[4:0]};
        endcase
      end
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  for (genvar i = 0; i < 2; i++) begin : g_alu
    always_comb {a_err[i], a_res[i]} = alu_fn(a_op[i], a_f3[i], a_f7[i], a_rs1[i], a_rs2[i], a_imm[i]);
  end

  alu_arbiter #(.FIXED_PRIORITY(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(q_rdy[0][0]), .req0_opcode(r_op[0]), .req0_funct3(r_f3[0]),
    .req0_funct7(r_f7[0]), .req0_rs1(r_rs1[0]), .req0_rs2(r_rs2[0]), .req0_imm(r_imm[0]),
    .req1_valid(v[1]), .req1_ready(q_rdy[0][1]), .req1_opcode(r_op[1]), .req1_funct3(r_f3[1]),
    .req1_funct7(r_f7[1]), .req1_rs1(r_rs1[1]), .req1_rs2(r_rs2[1]), .req1_imm(r_imm[1]),
    .resp0_valid(p_v[0][0]), .resp0_ready(rsp_rdy[0]), .resp0_result(p_res[0][0]), .resp0_error(p_err[0][0]),
    .resp1_valid(p_v[0][1]), .resp1_ready(rsp_rdy[1]), .resp1_result(p_res[0][1]), .resp1_error(p_err[0][1]),
    .alu_opcode(a_op[0]), .alu_funct3(a_f3[0]), .alu_funct7(a_f7[0]), .alu_rs1_value(a_rs1[0]),
    .alu_rs2_value(a_rs2[0]), .alu_imm(a_imm[0]), .alu_result(a_res[0]), .alu_error(a_err[0]),
    .error_count(ecnt[0])
  );

  alu_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v[0]), .req0_ready(q_rdy[1][0]), .req0_opcode(r_op[0]), .req0_funct3(r_f3[0]),
    .req0_funct7(r_f7[0]), .req0_rs1(r_rs1[0]), .req0_rs2(r_rs2[0]), .req0_imm(r_imm[0]),
    .req1_valid(v[1]), .req1_ready(q_rdy[1][1]), .req1_opcode(r_op[1]), .req1_funct3(r_f3[1]),
    .req1_funct7(r_f7[1]), .req1_rs1(r_rs1[1]), .req1_rs2(r_rs2[1]), .req1_imm(r_imm[1]),
    .resp0_valid(p_v[1][0]), .resp0_ready(rsp_rdy[0]), .resp0_result(p_res[1][0]), .resp0_error(p_err[1][0]),
    .resp1_valid(p_v[1][1]), .resp1_ready(rsp_rdy[1]), .resp1_result(p_res[1][1]), .resp1_error(p_err[1][1]),
    .alu_opcode(a_op[1]), .alu_funct3(a_f3[1]), .alu_funct7(a_f7[1]), .alu_rs1_value(a_rs1[1]),
    .alu_rs2_value(a_rs2[1]), .alu_imm(a_imm[1]), .alu_result(a_res[1]), .alu_error(a_err[1]),
    .error_count(ecnt[1])
  );

  // Behavioural model state, [instance][requester]
  bit          m_v   [2][2];
  logic [31:0] m_res [2][2];
  bit          m_err [2][2];
  int          m_ptr [2];
  int          m_cnt [2];
  int          last_grant [2];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0;
      m_cnt[i] = 0;
      for (int n = 0; n < 2; n++) begin
        m_v[i][n] = 0; m_res[i][n] = '0; m_err[i][n] = 0;
      end
    end
  endtask

  // Called just after a rising edge with inputs already set: checks at the
  // falling edge, advances the model across the next rising edge.
  task automatic step();
    int g;
    bit el [2];
    logic [32:0] r;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      for (int n = 0; n < 2; n++) el[n] = rst_n && v[n] && (!m_v[i][n] || rsp_rdy[n]);
      if (el[0] && el[1]) g = (i == 1) ? 0 : m_ptr[i];
      else if (el[0])     g = 0;
      else if (el[1])     g = 1;
      else                g = -1;
      last_grant[i] = g;
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("i%0d req%0d_ready", i, n), 32'(q_rdy[i][n]), 32'(g == n));
        chk($sformatf("i%0d resp%0d_valid", i, n), 32'(p_v[i][n]), 32'(m_v[i][n]));
        if (m_v[i][n] || !rst_n) begin
          chk($sformatf("i%0d resp%0d_result", i, n), p_res[i][n], m_res[i][n]);
          chk($sformatf("i%0d resp%0d_error", i, n), 32'(p_err[i][n]), 32'(m_err[i][n]));
        end
      end
      chk($sformatf("i%0d alu_opcode", i), 32'(a_op[i]), (g >= 0) ? 32'(r_op[g]) : 32'd0);
      chk($sformatf("i%0d alu_funct3", i), 32'(a_f3[i]), (g >= 0) ? 32'(r_f3[g]) : 32'd0);
      chk($sformatf("i%0d alu_funct7", i), 32'(a_f7[i]), (g >= 0) ? 32'(r_f7[g]) : 32'd0);
      chk($sformatf("i%0d alu_rs1", i), a_rs1[i], (g >= 0) ? r_rs1[g] : 32'd0);
      chk($sformatf("i%0d alu_rs2", i), a_rs2[i], (g >= 0) ? r_rs2[g] : 32'd0);
      chk($sformatf("i%0d alu_imm", i), a_imm[i], (g >= 0) ? r_imm[g] : 32'd0);
      chk($sformatf("i%0d error_count", i), 32'(ecnt[i]), 32'(m_cnt[i]));
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        g = last_grant[i];
        for (int n = 0; n < 2; n++) begin
          if (g == n) begin
            r = alu_fn(r_op[n], r_f3[n], r_f7[n], r_rs1[n], r_rs2[n], r_imm[n]);
            m_v[i][n] = 1; m_res[i][n] = r[31:0]; m_err[i][n] = r[32];
          end else if (m_v[i][n] && rsp_rdy[n]) begin
            m_v[i][n] = 0;
          end
        end
        if (g >= 0) begin
          m_ptr[i] = 1 - g;
          if (r_op[g] != 7'h00 && alu_fn(r_op[g], r_f3[g], r_f7[g], r_rs1[g], r_rs2[g], r_imm[g]) >> 32)
            m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
        end
      end
    end
    #1;
  endtask

  task automatic set_op(int n, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                        logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    r_op[n] = op; r_f3[n] = f3; r_f7[n] = f7; r_rs1[n] = a; r_rs2[n] = b; r_imm[n] = imm;
  endtask

  task automatic set_rand(int n);
    int sel;
    sel = $urandom_range(0, 5);
    set_op(n, 7'h33, 3'($urandom), 7'h00, $urandom, $urandom, $urandom);
    case (sel)
      0: r_op[n] = 7'h13;
      1: r_f7[n] = 7'h20;
      2: r_f7[n] = 7'h01;          // illegal funct7
      3: r_op[n] = 7'h7F;          // illegal opcode
      default: ;
    endcase
  endtask

  initial begin
    v = '0; rsp_rdy = '0;
    set_rand(0); set_rand(1);
    model_reset();

    // Reset held with requests pending: nothing granted, ALU bus quiet.
    #1; v = 2'b11; rsp_rdy = 2'b11;
    step(); step();
    rst_n = 1'b1;

    // Lone ADD on requester 0: 5 + 7 = 12 one cycle later.
    v = 2'b01; set_op(0, 7'h33, 3'd0, 7'h00, 32'd5, 32'd7, 32'd0);
    step();
    v = 2'b00;
    step();
    chk("add_result", p_res[0][0], 32'd12);
    chk("add_error", 32'(p_err[0][0]), 32'd0);

    // Both valid, responses always ready: RR alternates, FP stays on 0.
    v = 2'b11; rsp_rdy = 2'b11;
    for (int k = 0; k < 10; k++) begin set_rand(0); set_rand(1); step(); end

    // Backpressure on requester 1, then release: drain+refill in one edge.
    rsp_rdy = 2'b01;
    for (int k = 0; k < 6; k++) begin set_rand(0); set_rand(1); step(); end
    chk("req1_blocked", 32'(q_rdy[0][1]), 32'd0);
    rsp_rdy = 2'b11; v = 2'b10; set_rand(1);
    step();
    chk("drain_refill_valid", 32'(p_v[0][1]), 32'd1);

    // 300 illegal-funct7 ops: error flag on each, counter saturates at 255.
    v = 2'b01;
    set_op(0, 7'h33, 3'd0, 7'h05, 32'd1, 32'd2, 32'd0);
    for (int k = 0; k < 300; k++) step();
    v = 2'b00; step();
    chk("err_sat_rr", 32'(ecnt[0]), 32'd255);
    chk("err_sat_fp", 32'(ecnt[1]), 32'd255);
    chk("err_flag", 32'(p_err[0][0]), 32'd1);

    // Random traffic with random backpressure.
    for (int k = 0; k < 400; k++) begin
      v = 2'($urandom); rsp_rdy = 2'($urandom);
      set_rand(0); set_rand(1);
      step();
    end

    // Mid-operation reset: slot 0 full and blocked, slot 1 being filled.
    rsp_rdy = 2'b00; v = 2'b01; set_rand(0);
    step();
    v = 2'b10; set_rand(1);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("i%0d async_resp0_valid", i), 32'(p_v[i][0]), 32'd0);
      chk($sformatf("i%0d async_resp1_valid", i), 32'(p_v[i][1]), 32'd0);
      chk($sformatf("i%0d async_error_count", i), 32'(ecnt[i]), 32'd0);
    end
    model_reset();
    step();
    rst_n = 1'b1; v = 2'b11; rsp_rdy = 2'b11; set_rand(0); set_rand(1);
    @(negedge clk);
    chk("post_reset_tie_req0", 32'(q_rdy[0][0]), 32'd1);
    chk("post_reset_tie_req1", 32'(q_rdy[0][1]), 32'd0);
    @(posedge clk); #1;
    // the model did not see that edge; resynchronise it via a fresh reset
    rst_n = 1'b0; #1; model_reset(); step(); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin set_rand(0); set_rand(1); step(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 For N in {0,1}, the block SHALL have port reqN_valid, input, 1, requester N presents an operation.
REQ-005 For N in {0,1}, the block SHALL have port reqN_ready, output, 1, the operation of requester N is accepted this cycle.
REQ-006 For N in {0,1}, the block SHALL have ports reqN_opcode, reqN_funct3, reqN_funct7, reqN_rs1, reqN_rs2 and reqN_imm, inputs, widths 7/3/7/32/32/32, the operation fields.
REQ-007 For N in {0,1}, the block SHALL have port respN_valid, output, 1, a result is held for requester N.
REQ-008 For N in {0,1}, the block SHALL have port respN_ready, input, 1, requester N consumes its held result.
REQ-009 For N in {0,1}, the block SHALL have ports respN_result and respN_error, outputs, widths 32 and 1, the held ALU result and error flag.
REQ-010 The block SHALL have ports alu_opcode, alu_funct3, alu_funct7, alu_rs1_value, alu_rs2_value and alu_imm, outputs, widths 7/3/7/32/32/32, which drive the shared combinational ALU.
REQ-011 The block SHALL have ports alu_result and alu_error, inputs, widths 32 and 1, the same-cycle ALU outputs.
REQ-012 The block SHALL have port error_count, output, 8, a saturating count of accepted operations that flagged an error.

Function
REQ-013 Requester N SHALL be eligible in a cycle when reqN_valid=1 and its response slot is empty, or is full with respN_ready=1 in that cycle.
REQ-014 At most one requester SHALL be granted per cycle, and reqN_ready SHALL equal grantN; ready is combinational from valid, slot state and respN_ready.
REQ-015 When exactly one requester is eligible, that requester SHALL be granted.
REQ-016 When both requesters are eligible, the grant SHALL go to the priority pointer (rr_ptr, 1 bit), or always to requester 0 if FIXED_PRIORITY=1.
REQ-017 rr_ptr SHALL become the non-granted index on every grant and SHALL hold its value when no requester is granted.
REQ-018 The granted requester's fields SHALL drive the alu_* outputs combinationally in the grant cycle.
REQ-019 When no requester is granted, all alu_* outputs SHALL be 0 (opcode 0, so the ALU reports no error).
REQ-020 On the grant edge, alu_result and alu_error SHALL be written into slot N, and respN_valid SHALL be 1 from the next cycle (latency 1 cycle).
REQ-021 Aggregate throughput SHALL be one operation per cycle.
REQ-022 A slot SHALL clear on the edge where respN_valid=1 and respN_ready=1, unless the same edge refills it.
REQ-023 A simultaneous drain and refill SHALL keep respN_valid=1 and load the new data.
REQ-024 A full slot with respN_ready=0 SHALL hold its data stable and SHALL block requester N (reqN_ready=0).
REQ-025 The slots SHALL be independent: backpressure on one requester SHALL never block the other.
REQ-026 error_count SHALL increment by 1 on each grant edge with alu_error=1 and SHALL saturate at 255.
REQ-027 The reqN_* fields SHALL be ignored when reqN_valid=0.

Reset
REQ-028 While rst_n=0, independent of clk, both slots SHALL be empty (respN_valid=0), respN_result=0, respN_error=0, rr_ptr=0 and error_count=0.
REQ-029 During reset, reqN_ready SHALL be 0 and all alu_* outputs SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard held results with no partial-state retention.
REQ-031 The first grant SHALL be possible in the first cycle after rst_n deasserts.

Verification
REQ-032 Both requesters valid every cycle, resp ready tied 1, RR mode -> grants alternate 0,1,0,1; each resp valid 1 cycle after its accept.
REQ-033 req0 ADD rs1=5 rs2=7 alone -> alu_opcode=req0_opcode in grant cycle; next cycle resp0_result=12, resp0_error=0.
REQ-034 resp1_ready=0, two req1 ops back to back -> first accepted, req1_ready=0 afterwards; req0 still granted every cycle; raising resp1_ready drains and refills in the same cycle.
REQ-035 Illegal funct7 OP (alu_error=1) issued 300 times -> respN_error=1 on each; error_count=255 and holds.
REQ-036 FIXED_PRIORITY=1 with both valid -> req0 always granted; req1 granted only when req0_valid=0.
REQ-037 rst_n pulled low while slot 0 full and slot 1 filling -> respN_valid=0 and error_count=0 immediately without a clock edge; first post-reset tie goes to requester 0.
